// File: rtl/timer_clk_ena_gen_if.sv
// rtl/timer_clk_ena_gen_if.sv - control and strobe bundle between timer control register and prescaler
interface timer_clk_ena_gen_if;
    logic       run;
    logic       psc_clr;
    logic [2:0] clk_sel;
    logic       clk_ena;
    logic       sel_pending;
    logic [2:0] sel_active;

    modport master (
        output run, psc_clr, clk_sel,
        input  clk_ena, sel_pending, sel_active
    );

    modport slave (
        input  run, psc_clr, clk_sel,
        output clk_ena, sel_pending, sel_active
    );
endinterface

// File: rtl/timer_clk_ena_gen.sv
// rtl/timer_clk_ena_gen.sv - timer prescaler producing clk_ena; TIMER_EXT_CLK_EN adds ext_clk tick source
module timer_clk_ena_gen #(
    parameter int DIV_W = 4
) (
    input  logic clk,
    input  logic rst,
`ifdef TIMER_EXT_CLK_EN
    input  logic ext_clk,
`endif
    timer_clk_ena_gen_if.slave bus
);

    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       sel_act_q;
    logic             sel_pend_q;
    logic             ena_q;

    logic [2:0]       sel_req;
    logic             ext_rise;
    logic             ext_fall;
    logic             ext_mode_sw;
    logic [DIV_W-1:0] div_mask;
    logic             div_ratio;
    logic             div_hit;
    logic             div_wrap;
    logic             sel_diff;
    logic             sel_apply;
    logic             ena_nxt;

`ifdef TIMER_EXT_CLK_EN
    // [0],[1] resynchronise ext_clk, [2] holds the previous synchronised level for edge detection
    logic [2:0] ext_sync;

    // External tick synchroniser and edge-detect history
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_sync <= '0;
        end else begin
            ext_sync <= {ext_sync[1:0], ext_clk};
        end
    end

    assign ext_rise    = ext_sync[1] & ~ext_sync[2];
    assign ext_fall    = ~ext_sync[1] & ext_sync[2];
    assign sel_req     = bus.clk_sel;
    // Entering or leaving an external-tick mode never waits for a divider boundary
    assign ext_mode_sw = (sel_act_q[2:1] == 2'b11) || (sel_req[2:1] == 2'b11);
`else
    assign ext_rise    = 1'b0;
    assign ext_fall    = 1'b0;
    // Without the external source, requests 6/7 mean stop
    assign sel_req     = (bus.clk_sel[2:1] == 2'b11) ? 3'd0 : bus.clk_sel;
    assign ext_mode_sw = 1'b0;
`endif

    // Low-bit mask whose all-ones pattern marks the last cycle of the active divided period
    always_comb begin
        div_mask  = '0;
        div_ratio = 1'b0;
        case (sel_act_q)
            3'd2: begin div_mask = DIV_W'(1);  div_ratio = 1'b1; end
            3'd3: begin div_mask = DIV_W'(3);  div_ratio = 1'b1; end
            3'd4: begin div_mask = DIV_W'(7);  div_ratio = 1'b1; end
            3'd5: begin div_mask = DIV_W'(15); div_ratio = 1'b1; end
            default: begin div_mask = '0; div_ratio = 1'b0; end
        endcase
    end

    assign div_hit  = div_ratio && ((div_cnt & div_mask) == div_mask);
    assign div_wrap = (div_cnt == {DIV_W{1'b1}});
    assign sel_diff = (sel_req != sel_act_q);

    // Ratio switches only where the old and new periods align, so strobe spacing never shrinks;
    // stop and /1 have no phase to preserve and switch immediately
    assign sel_apply = sel_diff &&
                       ((sel_act_q[2:1] == 2'b00) || ext_mode_sw ||
                        (bus.run && (bus.psc_clr || div_wrap)));

    // Strobe decision always uses the ratio in effect before this edge
    always_comb begin
        ena_nxt = 1'b0;
        if (bus.run && !bus.psc_clr) begin
            case (sel_act_q)
                3'd1:    ena_nxt = 1'b1;
                3'd2,
                3'd3,
                3'd4,
                3'd5:    ena_nxt = div_hit;
                3'd6:    ena_nxt = ext_rise;
                3'd7:    ena_nxt = ext_fall;
                default: ena_nxt = 1'b0;
            endcase
        end
    end

    // Free-running divider: cleared by psc_clr, frozen while run is low
    always_ff @(posedge clk) begin
        if (rst || bus.psc_clr) begin
            div_cnt <= '0;
        end else if (bus.run) begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Active ratio, pending flag and registered strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_act_q  <= 3'd0;
            sel_pend_q <= 1'b0;
            ena_q      <= 1'b0;
        end else begin
            ena_q <= ena_nxt;
            if (sel_apply) begin
                sel_act_q  <= sel_req;
                sel_pend_q <= 1'b0;
            end else begin
                sel_pend_q <= sel_diff;
            end
        end
    end

    assign bus.clk_ena     = ena_q;
    assign bus.sel_pending = sel_pend_q;
    assign bus.sel_active  = sel_act_q;

endmodule
